uart_rx_sampler: RTL and testbench

//  UART receive stage; consumes the 16x baud_clock strobe from the CoreUART clock generator.

---
 rtl/uart_rx_sampler.sv | 156 +++++++++++++++
 tb/tb_uart_rx_sampler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// UART receive stage: synchronises rx, oversamples at 16x baud with 3-tick
// majority voting, recovers 7/8-bit frames with optional parity, and holds one
// received byte with parity/framing/overflow status for the consumer.
module uart_rx_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_data_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_idle
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_s;
  logic [3:0] samp_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       s7_q, s8_q;
  logic       bit8_q, par_q, odd_q;
  logic       perr_q;
  logic       armed_q;
  logic       done_q;
  logic [7:0] pend_byte_q;
  logic       pend_perr_q, pend_ferr_q;

  logic       active_tick, tick7, tick8, tick9, wrap;
  logic       maj, start_det, last_bit, stop_done;
  logic [7:0] data_aligned;

  assign rx_s        = sync_q[SYNC_STAGES-1];
  assign active_tick = baud_clock && (state_q != StIdle);
  assign tick7       = active_tick && (samp_cnt_q == 4'd7);
  assign tick8       = active_tick && (samp_cnt_q == 4'd8);
  assign tick9       = active_tick && (samp_cnt_q == 4'd9);
  assign wrap        = active_tick && (samp_cnt_q == 4'd15);
  assign maj         = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  // armed_q blocks a held-low line (break) from re-triggering a start.
  assign start_det   = baud_clock && (state_q == StIdle) && !rx_s && armed_q;
  assign last_bit    = (bit_cnt_q == (bit8_q ? 3'd7 : 3'd6));
  assign stop_done   = (state_q == StStop) && tick9;
  // Seven shifts leave the data in [7:1]; right-align with bit 7 cleared.
  assign data_aligned = bit8_q ? shift_q : {1'b0, shift_q[7:1]};
  assign rx_idle     = (state_q == StIdle);

  // rx synchroniser chain, idles high.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; every decision is qualified by a baud tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_det) state_d = StStart;
      StStart: begin
        if (tick9 && maj) state_d = StIdle;
        else if (wrap)    state_d = StData;
      end
      StData:   if (wrap && last_bit) state_d = par_q ? StParity : StStop;
      StParity: if (wrap) state_d = StStop;
      StStop:   if (tick9) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Sample counter, majority samples, shift register and per-frame config.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      bit8_q      <= 1'b0;
      par_q       <= 1'b0;
      odd_q       <= 1'b0;
      perr_q      <= 1'b0;
      armed_q     <= 1'b1;
      done_q      <= 1'b0;
      pend_byte_q <= 8'd0;
      pend_perr_q <= 1'b0;
      pend_ferr_q <= 1'b0;
    end else begin
      done_q <= stop_done;
      if (start_det) begin
        samp_cnt_q <= 4'd0;
        bit8_q     <= bit8;
        par_q      <= parity_en;
        odd_q      <= odd_n_even;
        perr_q     <= 1'b0;
      end else if (active_tick) begin
        samp_cnt_q <= samp_cnt_q + 4'd1;
      end
      if (tick7) s7_q <= rx_s;
      if (tick8) s8_q <= rx_s;
      if ((state_q == StStart) && wrap) bit_cnt_q <= 3'd0;
      if ((state_q == StData) && tick9) shift_q <= {maj, shift_q[7:1]};
      if ((state_q == StData) && wrap)  bit_cnt_q <= bit_cnt_q + 3'd1;
      if ((state_q == StParity) && tick9) perr_q <= (^data_aligned) ^ maj ^ odd_q;
      if (stop_done) begin
        pend_byte_q <= data_aligned;
        pend_perr_q <= par_q & perr_q;
        pend_ferr_q <= ~maj;
        armed_q     <= 1'b0;
      end
      if (baud_clock && (state_q == StIdle) && rx_s) armed_q <= 1'b1;
    end
  end

  // Holding register toward the consumer; a completion while full is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte       <= 8'd0;
      rx_data_ready <= 1'b0;
      parity_err    <= 1'b0;
      framing_err   <= 1'b0;
      overflow      <= 1'b0;
    end else if (done_q) begin
      if (!rx_data_ready || read_rx_byte) begin
        rx_byte       <= pend_byte_q;
        parity_err    <= pend_perr_q;
        framing_err   <= pend_ferr_q;
        rx_data_ready <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (read_rx_byte && rx_data_ready) begin
      rx_data_ready <= 1'b0;
      parity_err    <= 1'b0;
      framing_err   <= 1'b0;
      overflow      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: the driver serialises frames and
// queues the byte/flags a receiver should report; a monitor pops and compares
// each time the DUT presents a newly loaded byte.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_clock = 1'b0;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       read_rx_byte = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_data_ready, parity_err, framing_err, overflow, rx_idle;

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_ready = 1'b0;
  logic prev_read = 1'b0;

  uart_rx_sampler #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_clock   (baud_clock),
    .rx           (rx),
    .bit8         (bit8),
    .parity_en    (parity_en),
    .odd_n_even   (odd_n_even),
    .read_rx_byte (read_rx_byte),
    .rx_byte      (rx_byte),
    .rx_data_ready(rx_data_ready),
    .parity_err   (parity_err),
    .framing_err  (framing_err),
    .overflow     (overflow),
    .rx_idle      (rx_idle)
  );

  always #5 clk = ~clk;

  // 16x baud strobe: one clk high every 4 clk.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_clock = 1'b1;
      @(posedge clk);
      #1 baud_clock = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A new byte is presented when ready rises, or stays high across a read.
  always @(negedge clk) begin
    if (!reset && rx_data_ready && (!prev_ready || prev_read)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", rx_byte);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_byte", {24'd0, rx_byte}, {24'd0, mon_e.b});
        check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.pe});
        check("framing_err", {31'd0, framing_err}, {31'd0, mon_e.fe});
      end
    end
    prev_ready <= rx_data_ready;
    prev_read  <= read_rx_byte;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (64) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pe, input logic od,
                            input logic flip, input logic stopb, input bit push,
                            input bit scramble);
    logic [7:0] eb;
    logic       pbit;
    exp_t       e;
    eb   = b8 ? d : {1'b0, d[6:0]};
    // Parity bit that makes the total number of ones even (or odd).
    pbit = od ? ~(^eb) : (^eb);
    if (flip) pbit = ~pbit;
    e.b  = eb;
    e.pe = pe & flip;
    e.fe = ~stopb;
    if (push) exp_q.push_back(e);
    bit8       = b8;
    parity_en  = pe;
    odd_n_even = od;
    drive_bit(1'b0);
    if (scramble) begin
      bit8       = 1'($urandom);
      parity_en  = 1'($urandom);
      odd_n_even = 1'($urandom);
    end
    for (int i = 0; i < (b8 ? 8 : 7); i++) drive_bit(eb[i]);
    if (pe) drive_bit(pbit);
    drive_bit(stopb);
    rx = 1'b1;
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (rx_data_ready) break;
      @(posedge clk);
      #1;
    end
    if (i == 2000) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_pulse();
    read_rx_byte = 1'b1;
    @(posedge clk);
    #1 read_rx_byte = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_byte"}, {24'd0, rx_byte}, 32'd0);
    check({tag, "_ready"}, {31'd0, rx_data_ready}, 32'd0);
    check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_ferr"}, {31'd0, framing_err}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_idle"}, {31'd0, rx_idle}, 32'd1);
  endtask

  initial begin
    idle_clks(4);
    check_reset_vals("rst");
    reset = 1'b0;
    idle_clks(8);

    // 8N1 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ready();
    read_pulse();
    check("t1_ready_cleared", {31'd0, rx_data_ready}, 32'd0);
    idle_clks(20);

    // 7E1 0x41, wrong then correct parity.
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_ready();
    read_pulse();
    idle_clks(20);
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ready();
    read_pulse();
    idle_clks(20);

    // Short low glitch on the line is rejected.
    rx = 1'b0;
    idle_clks(24);
    rx = 1'b1;
    idle_clks(200);
    check("t3_idle", {31'd0, rx_idle}, 32'd1);
    check("t3_ready", {31'd0, rx_data_ready}, 32'd0);

    // Stop bit low: framing error, cleared by read.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ready();
    check("t4_ferr", {31'd0, framing_err}, 32'd1);
    read_pulse();
    check("t4_ready_cleared", {31'd0, rx_data_ready}, 32'd0);
    check("t4_ferr_cleared", {31'd0, framing_err}, 32'd0);
    idle_clks(32);

    // Back-to-back, no read: second byte dropped.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_clks(20);
    check("t5_byte_kept", {24'd0, rx_byte}, 32'h11);
    check("t5_overflow", {31'd0, overflow}, 32'd1);
    read_pulse();
    check("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
    idle_clks(20);

    // Back-to-back with a read on the completion clock.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        int j;
        for (j = 0; j < 2000; j++) begin
          @(posedge clk);
          #1;
          if (!rx_idle) break;
        end
        for (j = 0; j < 2000; j++) begin
          @(posedge clk);
          #1;
          if (rx_idle) break;
        end
        if (j == 2000) check("t5a_timeout", 32'd0, 32'd1);
        read_pulse();
      end
    join
    idle_clks(4);
    check("t5a_byte", {24'd0, rx_byte}, 32'h22);
    check("t5a_overflow", {31'd0, overflow}, 32'd0);
    check("t5a_ready", {31'd0, rx_data_ready}, 32'd1);
    read_pulse();
    idle_clks(20);

    // Reset mid-DATA with overflow and ready set.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx    = 1'b1;
    reset = 1'b1;
    idle_clks(2);
    check_reset_vals("t6");
    reset = 1'b0;
    idle_clks(100);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ready();
    check("t6_overflow", {31'd0, overflow}, 32'd0);
    read_pulse();
    idle_clks(20);

    // Randomised frames, config scrambled mid-frame.
    for (int k = 0; k < 30; k++) begin
      logic [7:0] d;
      logic       b8, pe, od, flip, stopb;
      d     = 8'($urandom);
      b8    = 1'($urandom);
      pe    = 1'($urandom);
      od    = 1'($urandom);
      flip  = ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 4) != 0);
      send_frame(d, b8, pe, od, flip, stopb, 1'b1, 1'b1);
      wait_ready();
      read_pulse();
      idle_clks(stopb ? $urandom_range(1, 20) : $urandom_range(20, 40));
    end

    // Break: line held low for many bit times.
    begin
      exp_t e;
      e.b  = 8'h00;
      e.pe = 1'b0;
      e.fe = 1'b1;
      bit8      = 1'b1;
      parity_en = 1'b0;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    idle_clks(64 * 12);
    check("brk_idle", {31'd0, rx_idle}, 32'd1);
    check("brk_ready", {31'd0, rx_data_ready}, 32'd1);
    read_pulse();
    idle_clks(64 * 2);
    check("brk_no_restart", {31'd0, rx_idle}, 32'd1);
    rx = 1'b1;
    idle_clks(64);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ready();
    read_pulse();
    idle_clks(50);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
